// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
//============================================================================
// Package  : pipelined_adder_pkg
// Brief    : Configuration helpers shared by the pipelined adder files.
// Revision : 1.0 - initial release
//============================================================================
package pipelined_adder_pkg;

    function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 0 : width / seg;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
//============================================================================
// Module   : adder_segment
// Brief    : W-bit combinational ripple-carry adder with carry in/out.
// Revision : 1.0 - initial release
//============================================================================
module adder_segment #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule : adder_segment
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
//============================================================================
// Module   : pipelined_adder
// Brief    : Segmented pipelined adder/subtractor, one stage per segment,
//            valid/ready handshake with full backpressure.
// Options  : OVERFLOW_FLAG_EN adds the registered signed-overflow output ovf.
// Revision : 1.0 - initial release
//============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG");
    end

    typedef struct packed {
        logic           carry;
        logic [SEG-1:0] psum;
    } stage_rec_t;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] sum_lo;

    logic [NSEG-1:0]  vld_q;
    logic [NSEG-1:0]  vld_d;
    stage_rec_t       stg_q  [NSEG];
    stage_rec_t       stg_d  [NSEG];
    stage_rec_t       stg_nx [NSEG];

    // The whole pipe advances together: it only holds when a result is stuck.
    assign adv       = !vld_q[NSEG-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NSEG-1];
    assign b_eff     = sub ? ~b : b;
    assign cin_eff   = cin ^ sub;
    assign sum       = {stg_q[NSEG-1].carry, sum_lo};

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < NSEG; k++) begin
            stg_d[k] = stg_q[k];
        end
        if (adv) begin
            vld_d[0] = in_valid;
            for (int k = 1; k < NSEG; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            for (int k = 0; k < NSEG; k++) begin
                stg_d[k] = stg_nx[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < NSEG; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < NSEG; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_nx;
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = adv ? ovf_nx : ovf_q;
    assign ovf   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    for (genvar j = 0; j < NSEG; j++) begin : g_seg
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic           seg_ci;
        logic [SEG-1:0] seg_s;
        logic           seg_co;

        if (j == 0) begin : g_first
            assign seg_a  = a[SEG-1:0];
            assign seg_b  = b_eff[SEG-1:0];
            assign seg_ci = cin_eff;
        end else begin : g_skew
            // Segment j of the operands waits j cycles for its carry to arrive.
            logic [SEG-1:0] adly_q [j];
            logic [SEG-1:0] adly_d [j];
            logic [SEG-1:0] bdly_q [j];
            logic [SEG-1:0] bdly_d [j];

            always_comb begin
                for (int i = 0; i < j; i++) begin
                    adly_d[i] = adly_q[i];
                    bdly_d[i] = bdly_q[i];
                end
                if (adv) begin
                    adly_d[0] = a[j*SEG +: SEG];
                    bdly_d[0] = b_eff[j*SEG +: SEG];
                    for (int i = 1; i < j; i++) begin
                        adly_d[i] = adly_q[i-1];
                        bdly_d[i] = bdly_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < j; i++) begin
                        adly_q[i] <= '0;
                        bdly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < j; i++) begin
                        adly_q[i] <= adly_d[i];
                        bdly_q[i] <= bdly_d[i];
                    end
                end
            end

            assign seg_a  = adly_q[j-1];
            assign seg_b  = bdly_q[j-1];
            assign seg_ci = stg_q[j-1].carry;
        end

        adder_segment #(.W(SEG)) u_add (
            .a    (seg_a),
            .b    (seg_b),
            .cin  (seg_ci),
            .s    (seg_s),
            .cout (seg_co)
        );

        assign stg_nx[j] = {seg_co, seg_s};

        if (j == NSEG - 1) begin : g_out_direct
            assign sum_lo[j*SEG +: SEG] = stg_q[j].psum;
`ifdef OVERFLOW_FLAG_EN
            assign ovf_nx = (seg_a[SEG-1] == seg_b[SEG-1]) && (seg_s[SEG-1] != seg_a[SEG-1]);
`endif
        end else begin : g_out_dly
            localparam int unsigned D = NSEG - 1 - j;
            logic [SEG-1:0] odly_q [D];
            logic [SEG-1:0] odly_d [D];

            always_comb begin
                for (int i = 0; i < D; i++) begin
                    odly_d[i] = odly_q[i];
                end
                if (adv) begin
                    odly_d[0] = stg_q[j].psum;
                    for (int i = 1; i < D; i++) begin
                        odly_d[i] = odly_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        odly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < D; i++) begin
                        odly_q[i] <= odly_d[i];
                    end
                end
            end

            assign sum_lo[j*SEG +: SEG] = odly_q[D-1];
        end
    end

endmodule : pipelined_adder
`default_nettype wire
